// File: rtl/rf_pkg.sv
// Shared register-file definitions: widths, the zero register and writeback enums.
package rf_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  // Width of the ALU starvation counter; limits above 15 are not representable.
  localparam int unsigned STARVE_CNT_W = 4;

  typedef enum logic {
    NORMAL,
    FORCE_ALU
  } wb_state_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_MEM
  } wb_src_t;

endpackage

// File: rtl/wb_starve_ctr.sv
// Saturating starvation counter. hold beats clr, clr beats inc.
// reached_limit flags that the increment applied at this edge lands exactly on LIMIT.
module wb_starve_ctr
  import rf_pkg::*;
#(
  parameter int unsigned LIMIT = 3,
  parameter int unsigned CNT_W = STARVE_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  input  logic hold,
  output logic reached_limit
);

  localparam logic [CNT_W-1:0] LIMIT_CNT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: freeze on hold, zero on clr, otherwise saturate-increment.
  always_comb begin
    cnt_d = cnt_q;
    if (hold) begin
      cnt_d = cnt_q;
    end else if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q < LIMIT_CNT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Limit is reached only by an increment at this edge.
  always_comb begin
    reached_limit = inc && !hold && !clr && (cnt_d == LIMIT_CNT);
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the register file's single write port. MEM normally wins;
// after STARVE_LIMIT consecutive ALU losses the ALU is forced to win once.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W       = REG_DATA_W,
  parameter int unsigned ADDR_W       = REG_ADDR_W,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              starve_active
);

  wb_state_t state_q, state_d;
  wb_src_t   grant;
  logic      cnt_inc, cnt_clr, reached_limit;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  wb_starve_ctr #(
    .LIMIT(STARVE_LIMIT),
    .CNT_W(STARVE_CNT_W)
  ) u_starve_ctr (
    .clk          (clk),
    .rst          (rst),
    .inc          (cnt_inc),
    .clr          (cnt_clr),
    .hold         (stall),
    .reached_limit(reached_limit)
  );

  // State register; starve_active mirrors the registered state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= NORMAL;
      starve_active <= 1'b0;
    end else begin
      state_q       <= state_d;
      starve_active <= (state_d == FORCE_ALU);
    end
  end

  // Next state and counter controls; stall freezes both.
  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    if (!stall) begin
      unique case (state_q)
        NORMAL: begin
          cnt_inc = mem_valid && alu_valid;
          cnt_clr = !alu_valid || (grant == SRC_ALU);
          if (reached_limit) state_d = FORCE_ALU;
        end
        FORCE_ALU: begin
          // Leave after an ALU grant, or immediately if the ALU withdrew.
          cnt_clr = 1'b1;
          state_d = NORMAL;
        end
        default: state_d = NORMAL;
      endcase
    end
  end

  // Grant selection and combinational readys.
  always_comb begin
    grant = SRC_NONE;
    if (!stall && !rst) begin
      if (state_q == FORCE_ALU) begin
        if (alu_valid)      grant = SRC_ALU;
        else if (mem_valid) grant = SRC_MEM;
      end else begin
        if (mem_valid)      grant = SRC_MEM;
        else if (alu_valid) grant = SRC_ALU;
      end
    end
    alu_ready = (grant == SRC_ALU);
    mem_ready = (grant == SRC_MEM);
    win_rd    = (grant == SRC_MEM) ? mem_rd : alu_rd;
    win_data  = (grant == SRC_MEM) ? mem_data : alu_data;
  end

  // Write-port registers; writes to r0 are consumed with rf_we low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
    end else if (grant != SRC_NONE) begin
      rf_we    <= (win_rd != ADDR_W'(REG_ZERO));
      rf_rd    <= win_rd;
      rf_wdata <= win_data;
    end else begin
      rf_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a behavioural model.
module tb_rf_wb_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned LIM = 3;

  logic          clk = 1'b0;
  logic          rst, stall;
  logic          alu_valid, mem_valid, alu_ready, mem_ready;
  logic [AW-1:0] alu_rd, mem_rd, rf_rd;
  logic [DW-1:0] alu_data, mem_data, rf_wdata;
  logic          rf_we, starve_active;

  rf_wb_arbiter #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .rf_we        (rf_we),
    .rf_rd        (rf_rd),
    .rf_wdata     (rf_wdata),
    .starve_active(starve_active)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: whether the ALU is owed a win, and how many times in a row it lost.
  bit            m_owed;
  int            m_losses;
  bit            e_we;
  logic [AW-1:0] e_rd;
  logic [DW-1:0] e_wdata;
  int            last_grant;  // 0 none, 1 alu, 2 mem

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owed     = 1'b0;
    m_losses   = 0;
    e_we       = 1'b0;
    e_rd       = '0;
    e_wdata    = '0;
    last_grant = 0;
  endtask

  // One clock: drive at negedge, check readys, then check registered outputs after the edge.
  task automatic step(input bit st, input bit av, input logic [AW-1:0] ard,
                      input logic [DW-1:0] ad, input bit mv, input logic [AW-1:0] mrd,
                      input logic [DW-1:0] md);
    int g;
    @(negedge clk);
    stall = st; alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    g = 0;
    if (!st) begin
      if (m_owed) g = av ? 1 : (mv ? 2 : 0);
      else        g = mv ? 2 : (av ? 1 : 0);
    end
    check_eq("alu_ready", alu_ready, g == 1);
    check_eq("mem_ready", mem_ready, g == 2);
    @(posedge clk);
    #1;
    if (!st) begin
      if (m_owed) begin
        m_owed   = 1'b0;
        m_losses = 0;
      end else if (g == 2 && av) begin
        m_losses++;
        if (m_losses >= LIM) m_owed = 1'b1;
      end else begin
        m_losses = 0;
      end
    end
    if (g == 1) begin
      e_we = (ard != 0); e_rd = ard; e_wdata = ad;
    end else if (g == 2) begin
      e_we = (mrd != 0); e_rd = mrd; e_wdata = md;
    end else begin
      e_we = 1'b0;
    end
    check_eq("rf_we", rf_we, e_we);
    check_eq("rf_rd", rf_rd, e_rd);
    check_eq("rf_wdata", rf_wdata, e_wdata);
    check_eq("starve_active", starve_active, m_owed);
    last_grant = g;
  endtask

  initial begin
    bit            av, mv, st;
    logic [AW-1:0] ard, mrd;
    logic [DW-1:0] ad, md;

    rst = 1'b1; stall = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    model_reset();
    #1;
    check_eq("reset_we", rf_we, 0);
    check_eq("reset_rd", rf_rd, 0);
    check_eq("reset_wdata", rf_wdata, 0);
    check_eq("reset_starve", starve_active, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single ALU write, then idle.
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    check_eq("single_rd", rf_rd, 5);
    check_eq("single_wdata", rf_wdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0);
    check_eq("single_idle_we", rf_we, 0);

    // Both valid: MEM first, ALU next.
    step(0, 1, 4, 32'h22, 1, 3, 32'h11);
    check_eq("both_first_rd", rf_rd, 3);
    step(0, 1, 4, 32'h22, 0, 0, 0);
    check_eq("both_second_rd", rf_rd, 4);

    // Starvation: MEM wins LIM times, then the ALU is forced through.
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 9, 32'hAA, 1, AW'(10 + i), 32'(100 + i));
      if (i == 2) check_eq("starve_set", starve_active, 1);
    end
    check_eq("starve_alu_rd", rf_rd, 9);
    check_eq("starve_clear", starve_active, 0);
    step(0, 0, 0, 0, 0, 0, 0);

    // Write to r0 is accepted but silent.
    step(0, 1, 0, 32'h5, 0, 0, 0);
    check_eq("r0_we", rf_we, 0);

    // Stall holds the loss count: 1 loss, 2 stalls, then 2 more losses force the ALU.
    step(0, 1, 2, 32'h2, 1, 6, 32'h60);
    step(1, 1, 2, 32'h2, 1, 6, 32'h61);
    check_eq("stall_we", rf_we, 0);
    step(1, 1, 2, 32'h2, 1, 6, 32'h61);
    step(0, 1, 2, 32'h2, 1, 6, 32'h61);
    check_eq("post_stall_rd", rf_rd, 6);
    step(0, 1, 2, 32'h2, 1, 8, 32'h62);
    check_eq("stall_held_cnt", starve_active, 1);
    step(0, 1, 2, 32'h2, 0, 0, 0);
    check_eq("stall_alu_rd", rf_rd, 2);

    // Asynchronous reset right after a grant drops the in-flight write.
    step(0, 1, 7, 32'h77, 0, 0, 0);
    rst = 1'b1;
    #1;
    check_eq("mid_reset_we", rf_we, 0);
    check_eq("mid_reset_rd", rf_rd, 0);
    check_eq("mid_reset_wdata", rf_wdata, 0);
    check_eq("mid_reset_starve", starve_active, 0);
    check_eq("mid_reset_ready", alu_ready, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 7, 32'h77, 0, 0, 0);
    check_eq("after_reset_rd", rf_rd, 7);

    // Random traffic; pending requests hold rd/data, occasionally withdrawing.
    av = 0; mv = 0; ard = '0; mrd = '0; ad = '0; md = '0;
    for (int i = 0; i < 500; i++) begin
      if (av && last_grant != 1) begin
        if ($urandom_range(0, 99) < 10) av = 0;
      end else begin
        av = ($urandom_range(0, 99) < 60); ard = AW'($urandom); ad = $urandom;
      end
      if (mv && last_grant != 2) begin
        if ($urandom_range(0, 99) < 10) mv = 0;
      end else begin
        mv = ($urandom_range(0, 99) < 70); mrd = AW'($urandom); md = $urandom;
      end
      st = ($urandom_range(0, 99) < 15);
      step(st, av, ard, ad, mv, mrd, md);
      if (st) last_grant = 0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter for the 32x32 register file's single write port. Two writeback sources compete for the port through valid/ready handshakes: ALU results and load (MEM) results. The block picks one per cycle with starvation protection and registers the chosen write onto the register file's RegWrite/rd/write_data inputs. It sits between the execute/memory stages and the register file.

## Interface
- DATA_W, 32, writeback data width
- ADDR_W, 5, register index width
- STARVE_LIMIT, 3, consecutive ALU losses before ALU is forced to win (1..15)
- clk  in  1  clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- stall  in  1  when high, no grants issued; pending requests wait
- alu_valid  in  1  ALU writeback request
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- mem_valid  in  1  load writeback request
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- mem_ready  out  1  load request accepted this cycle (combinational)
- rf_we  out  1  register file RegWrite
- rf_rd  out  ADDR_W  register file write index
- rf_wdata  out  DATA_W  register file write data
- starve_active  out  1  high while in FORCE_ALU state

## Operation
- Transfer on a source = valid && ready at a rising clk edge. Requesters hold rd/data stable while valid && !ready.
- At most one ready is high per cycle. Both readys are 0 while stall=1 or rst=1.
- States: NORMAL, FORCE_ALU.
  - NORMAL: mem_valid wins over alu_valid. If both are valid and MEM wins, starve_cnt increments. Any ALU grant, or a cycle without alu_valid, clears starve_cnt. When starve_cnt reaches STARVE_LIMIT, go to FORCE_ALU at the same edge.
  - FORCE_ALU: alu_valid wins over mem_valid. After the first ALU grant, return to NORMAL with starve_cnt=0. If alu_valid drops before a grant, return to NORMAL with starve_cnt=0 and no grant is lost.
- Stall cycles neither increment nor clear starve_cnt, and the state does not change.
- On an accepted transfer, the next edge loads rf_rd and rf_wdata from the winner. rf_we=1 unless the winner's rd is 0.
  - A write to register 0 is still accepted (ready=1) but produces rf_we=0, so it is consumed silently.
- In a cycle with no transfer, rf_we goes to 0. rf_rd and rf_wdata hold their previous values.
- Widths: no arithmetic on data. starve_cnt is 4 bits and saturates at STARVE_LIMIT.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_wdata=0, starve_active=0, state=NORMAL, starve_cnt=0. Reset asserted mid-operation clears all of these immediately (asynchronously); any in-flight registered write is dropped.
- Latency: request accepted at edge N → rf_we/rf_rd/rf_wdata valid during cycle N..N+1 → register file updated at edge N+1.
- Throughput: one write per cycle. Back-to-back grants to the same source are allowed.
- Both sources valid with the same rd: only the winner writes this cycle. The loser writes later, so the final register value belongs to the later-granted source. Ordering between sources is the requesters' responsibility.
- starve_active is registered and equals (state == FORCE_ALU).
- stall rising while a request is pending: ready drops combinationally in that cycle, and rf_we=0 on the next edge.

## Structure
- Shared package rf_pkg holds:
  - REG_ADDR_W=5 and REG_DATA_W=32
  - REG_ZERO=5'd0
  - enum wb_state_t {NORMAL, FORCE_ALU}
  - enum wb_src_t {SRC_NONE, SRC_ALU, SRC_MEM}
- The register file itself stays a separate module; this block only drives its write port.
- One sub-module is natural: wb_starve_ctr, a saturating counter with inc/clr/hold inputs and a reached_limit output.
- Grant logic and output registers stay in the top module.

## Test plan
- Reset: assert rst mid-stream with alu_valid=1, rd=7 → rf_we=0, rf_rd=0, rf_wdata=0, starve_active=0 immediately; after release, the ALU write reaches the port one edge after its grant.
- Single ALU write rd=5, data=0xDEADBEEF → alu_ready=1 in the same cycle; next edge rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF; the following cycle rf_we=0.
- Both valid (mem rd=3/0x11, alu rd=4/0x22) → MEM granted first (rf_rd=3), ALU granted next cycle (rf_rd=4).
- Starvation, STARVE_LIMIT=3: mem_valid and alu_valid both held high with MEM issuing new requests → MEM wins 3 cycles, starve_active=1, then the ALU grant is observed on the 4th grant cycle, then back to NORMAL.
- Register 0: alu_valid with rd=0, data=0x5 → alu_ready=1; rf_we stays 0 on the next edge.
- Stall: stall=1 for 2 cycles with mem_valid=1 → mem_ready=0 and rf_we=0 throughout, starve_cnt unchanged; grant occurs in the first cycle after stall drops.
